gamepad_pmod_tx: RTL and testbench



---
 rtl/gamepad_pmod_tx.sv | 129 ++++++++++++
 tb/tb_gamepad_pmod_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: serialises {buttons2, buttons1} MSB first on
// data/clock, then strobes latch, then idles for a gap before the next frame.
module gamepad_pmod_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] buttons1,
  input  logic [11:0] buttons2,
  output logic        pmod_data,
  output logic        pmod_clk,
  output logic        pmod_latch,
  output logic        busy,
  output logic        frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  state_t          state, state_n;
  logic [23:0]     shift, shift_n;
  logic [4:0]      bit_cnt, bit_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [GW-1:0]   gap_cnt, gap_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_n;
      div_cnt <= div_n;
      gap_cnt <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    div_n   = div_cnt;
    gap_n   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = SHIFT_LO;
          shift_n = {buttons2, buttons1};
          bit_n   = '0;
          div_n   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_cnt == DIV_LAST) begin
          state_n = SHIFT_HI;
          div_n   = '0;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (bit_cnt == 5'd23) begin
            state_n = LATCH;
          end else begin
            state_n = SHIFT_LO;
            shift_n = {shift[22:0], 1'b0};
            bit_n   = bit_cnt + 5'd1;
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          gap_n   = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so each one shows the
  // decode of the state held during the same cycle, with no glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmod_data  <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pmod_data  <= ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) && shift_n[23];
      pmod_clk   <= (state_n == SHIFT_HI);
      pmod_latch <= (state_n == LATCH);
      busy       <= (state_n != IDLE);
      frame_done <= (state_n == LATCH) && (div_n == DIV_LAST);
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench for gamepad_pmod_tx with a behavioural receiver that shifts on
// pmod_clk rising edges and captures the word while pmod_latch is high.
module tb_gamepad_pmod_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] buttons1 = '0;
  logic [11:0] buttons2 = '0;
  logic        pmod_data, pmod_clk, pmod_latch, busy, frame_done;

  gamepad_pmod_tx #(.CLK_DIV(4), .GAP_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .buttons1   (buttons1),
    .buttons2   (buttons2),
    .pmod_data  (pmod_data),
    .pmod_clk   (pmod_clk),
    .pmod_latch (pmod_latch),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model and frame recorder
  int          frame_cnt = 0, cur_bits = 0, cur_latch = 0, cur_done = 0;
  int          cur_start = 0, rise_total = 0, total_done = 0, overlap = 0, last_end = 0;
  logic [23:0] rx = '0, cur_word = '0;
  logic        prev_clk = 1'b0, prev_latch = 1'b0;
  int          f_start [16];
  int          f_bits  [16];
  int          f_latch [16];
  int          f_done  [16];
  logic [23:0] f_word  [16];

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      cur_bits = 0; rx = '0; cur_latch = 0; cur_done = 0;
      prev_clk = 1'b0; prev_latch = 1'b0;
    end else begin
      if (pmod_clk && !prev_clk) begin
        if (cur_bits == 0) cur_start = cyc;
        rx = {rx[22:0], pmod_data};
        cur_bits++;
        rise_total++;
      end
      if (pmod_latch && pmod_clk) overlap++;
      if (frame_done) total_done++;
      if (pmod_latch) begin
        if (!prev_latch) cur_word = rx;
        cur_latch++;
        if (frame_done) cur_done++;
      end
      if (prev_latch && !pmod_latch && frame_cnt < 16) begin
        f_start[frame_cnt] = cur_start;
        f_bits[frame_cnt]  = cur_bits;
        f_latch[frame_cnt] = cur_latch;
        f_done[frame_cnt]  = cur_done;
        f_word[frame_cnt]  = cur_word;
        frame_cnt++;
        cur_bits = 0; cur_latch = 0; cur_done = 0;
        last_end = cyc;
      end
      prev_clk = pmod_clk;
      prev_latch = pmod_latch;
    end
  end

  task automatic wait_frames(input int n);
    int budget = 0;
    while (frame_cnt < n && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (frame_cnt < n) check("timeout_frame", frame_cnt, n);
  endtask

  task automatic wait_bits(input int n);
    int budget = 0;
    while (!(cur_bits >= n && pmod_clk) && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 1000) check("timeout_bits", cur_bits, n);
  endtask

  int release_cyc, rise_snap, budget;

  initial begin
    // Reset held with enable high: nothing may move
    enable = 1'b1; buttons2 = 12'h000; buttons1 = 12'hA5C;
    repeat (10) @(negedge clk);
    check("rst_data",  pmod_data,  1'b0);
    check("rst_clk",   pmod_clk,   1'b0);
    check("rst_latch", pmod_latch, 1'b0);
    check("rst_busy",  busy,       1'b0);
    check("rst_done",  frame_done, 1'b0);
    check("rst_edges", rise_total, 0);
    reset = 1'b0;
    release_cyc = cyc;

    wait_frames(1);
    check("first_rise_lat", f_start[0] - release_cyc, 5);
    check("f0_bits",  f_bits[0],  24);
    check("f0_word",  f_word[0],  24'h000A5C);
    check("f0_latch", f_latch[0], 4);
    check("f0_done",  f_done[0],  1);

    wait_frames(2);
    check("frame_period", f_start[1] - f_start[0], 213);
    buttons1 = 12'h080;

    wait_frames(3);
    check("loop_080", f_word[2], 24'h000080);
    check("loop_up",  f_word[2][7], 1'b1);
    buttons1 = 12'h800;

    wait_frames(4);
    check("loop_800", f_word[3], 24'h000800);
    check("loop_b",   f_word[3][11], 1'b1);
    buttons1 = 12'h001;

    wait_frames(5);
    check("loop_001", f_word[4], 24'h000001);
    check("loop_r",   f_word[4][0], 1'b1);
    buttons1 = 12'hFFF;

    // Change the inputs during bit 15 of the frame in flight
    wait_bits(15);
    buttons1 = 12'h000;
    wait_frames(6);
    check("snap_cur",  f_word[5], 24'h000FFF);
    wait_frames(7);
    check("snap_next", f_word[6], 24'h000000);

    buttons2 = 12'h9A1; buttons1 = 12'h3C5;
    wait_bits(6);
    check("drop_in_hi", pmod_clk, 1'b1);
    enable = 1'b0;
    wait_frames(8);
    check("drop_bits",  f_bits[7],  24);
    check("drop_word",  f_word[7],  24'h9A13C5);
    check("drop_latch", f_latch[7], 4);
    check("drop_done",  f_done[7],  1);
    budget = 0;
    while (busy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("busy_fall_gap", cyc - last_end, 16);
    rise_snap = rise_total;
    repeat (300) @(negedge clk);
    check("idle_no_edges", rise_total, rise_snap);
    check("idle_busy",     busy, 1'b0);

    // Short asynchronous reset pulse while pmod_clk is high
    buttons2 = 12'hFFF; buttons1 = 12'h5A5; enable = 1'b1;
    wait_bits(3);
    check("pre_arst_clk",  pmod_clk,  1'b1);
    check("pre_arst_data", pmod_data, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_clk",  pmod_clk,  1'b0);
    check("arst_busy", busy,      1'b0);
    check("arst_data", pmod_data, 1'b0);
    reset = 1'b0;
    #1;
    check("post_arst_clk", pmod_clk, 1'b0);
    wait_frames(9);
    check("arst_bits", f_bits[8], 24);
    check("arst_word", f_word[8], 24'hFFF5A5);

    check("latch_clk_overlap", overlap, 0);
    check("done_per_frame", total_done, frame_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
